// File: rtl/ghost_mode_scheduler_if.sv
// ghost_mode_scheduler_if
//   Bundles the frame/event inputs and the mode outputs of the ghost mode
//   scheduler. The master side (game logic / bench) drives the event inputs;
//   the slave side (the scheduler) drives the mode outputs.
//   Inputs : frame_tick, game_start, freeze, power_pellet, ghost_eaten[3:0],
//            ghost_home[3:0]
//   Outputs: game_mode[3:0][1:0], base_mode[1:0], phase[2:0], fright_active,
//            fright_ending, fright_flash, reverse_req
interface ghost_mode_scheduler_if;
  logic            frame_tick;
  logic            game_start;
  logic            freeze;
  logic            power_pellet;
  logic [3:0]      ghost_eaten;
  logic [3:0]      ghost_home;
  logic [3:0][1:0] game_mode;
  logic [1:0]      base_mode;
  logic [2:0]      phase;
  logic            fright_active;
  logic            fright_ending;
  logic            fright_flash;
  logic            reverse_req;

  modport master (
    output frame_tick, game_start, freeze, power_pellet, ghost_eaten, ghost_home,
    input  game_mode, base_mode, phase, fright_active, fright_ending,
           fright_flash, reverse_req
  );

  modport slave (
    input  frame_tick, game_start, freeze, power_pellet, ghost_eaten, ghost_home,
    output game_mode, base_mode, phase, fright_active, fright_ending,
           fright_flash, reverse_req
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler
//   Global ghost-behaviour sequencer: times the scatter/chase schedule in
//   frame ticks, overlays the frightened period after a power pellet and
//   tracks each ghost's eaten/returning state.
//   Ports: clk, resetN (async, active low), bus (ghost_mode_scheduler_if.slave)
//   Optional: define FRIGHT_FLASH_EN to build the fright_flash blink strobe;
//   otherwise fright_flash is tied 0.

// Per-ghost frightened/eaten tracker. Mode is derived purely from the two
// flags and the registered base mode, so it changes one clock after the event.
module ghost_lane (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_clear,
  input  logic       i_eat,
  input  logic       i_home,
  input  logic       i_pellet,
  input  logic       i_exit,
  input  logic [1:0] i_base,
  output logic [1:0] o_mode
);
  logic r_frt, r_eat;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frt <= 1'b0;
      r_eat <= 1'b0;
    end else if (i_clear) begin
      r_frt <= 1'b0;
      r_eat <= 1'b0;
    end else if (i_eat && r_frt) begin
      // eaten beats a simultaneous home pulse
      r_eat <= 1'b1;
      r_frt <= 1'b0;
    end else if (i_home && r_eat) begin
      r_eat <= 1'b0;           // back to base mode, never straight to frightened
    end else if (i_pellet && !r_eat) begin
      r_frt <= 1'b1;
    end else if (i_exit) begin
      r_frt <= 1'b0;
    end
  end

  assign o_mode = r_eat ? 2'b11 : (r_frt ? 2'b10 : i_base);
endmodule

module ghost_mode_scheduler #(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int NUM_PHASES     = 7,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FLASH_FRAMES   = 120,
  parameter int CNT_W          = 12
) (
  input logic                   clk,
  input logic                   resetN,
  ghost_mode_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCATTER, CHASE, CHASE_FOREVER} state_t;

  localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SCATTER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CH_LAST = CNT_W'(CHASE_FRAMES - 1);
  localparam logic [CNT_W-1:0] FR_LAST = CNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [CNT_W-1:0] FR_END  = CNT_W'(FRIGHT_FRAMES - FLASH_FRAMES);
  localparam logic [2:0]       NPH     = 3'(NUM_PHASES);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_ptmr, r_ftmr;
  logic             r_fright, r_rev;
  logic             w_pellet, w_ptick, w_ftick, w_timed, w_pexp, w_fexit, w_ending;
  logic [CNT_W-1:0] w_pdur_last;
  logic [1:0]       w_base;

  // game_start overrides everything; pellets are meaningless before the game runs
  assign w_pellet    = bus.power_pellet && (r_state != IDLE) && !bus.game_start;
  // schedule time stands still while frightened or frozen
  assign w_ptick     = bus.frame_tick && !bus.freeze && !r_fright;
  assign w_ftick     = bus.frame_tick && !bus.freeze && r_fright;
  assign w_timed     = (r_state == SCATTER) || (r_state == CHASE);
  assign w_pdur_last = (r_state == SCATTER) ? SC_LAST : CH_LAST;
  assign w_pexp      = w_timed && w_ptick && (r_ptmr == w_pdur_last) && !bus.game_start;
  // a pellet landing on the last fright tick restarts rather than ends fright
  assign w_fexit     = w_ftick && (r_ftmr == FR_LAST) && !w_pellet && !bus.game_start;
  assign w_phase_nxt = r_phase + 3'd1;
  assign w_ending    = r_fright && (r_ftmr >= FR_END);
  assign w_base      = ((r_state == CHASE) || (r_state == CHASE_FOREVER)) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.game_start)            w_state_nxt = SCATTER;
    else if (w_pexp) begin
      if (w_phase_nxt == NPH)      w_state_nxt = CHASE_FOREVER;
      else if (w_phase_nxt[0])     w_state_nxt = CHASE;
      else                         w_state_nxt = SCATTER;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_phase  <= '0;
      r_ptmr   <= '0;
      r_ftmr   <= '0;
      r_fright <= 1'b0;
      r_rev    <= 1'b0;
    end else begin
      r_rev <= !bus.game_start && (w_pellet || w_pexp);
      if (bus.game_start) begin
        r_phase <= '0;
        r_ptmr  <= '0;
      end else if (w_pexp) begin
        r_phase <= w_phase_nxt;
        r_ptmr  <= '0;
      end else if (w_timed && w_ptick) begin
        r_ptmr  <= r_ptmr + 1'b1;
      end
      if (bus.game_start) begin
        r_fright <= 1'b0;
        r_ftmr   <= '0;
      end else if (w_pellet) begin
        r_fright <= 1'b1;
        r_ftmr   <= '0;
      end else if (w_fexit) begin
        r_fright <= 1'b0;
        r_ftmr   <= '0;
      end else if (w_ftick) begin
        r_ftmr   <= r_ftmr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    ghost_lane u_lane (
      .clk     (clk),
      .resetN  (resetN),
      .i_clear (bus.game_start),
      .i_eat   (bus.ghost_eaten[g]),
      .i_home  (bus.ghost_home[g]),
      .i_pellet(w_pellet),
      .i_exit  (w_fexit),
      .i_base  (w_base),
      .o_mode  (bus.game_mode[g])
    );
  end

`ifdef FRIGHT_FLASH_EN
  logic [3:0]       r_fcnt;
  logic             r_flash;
  logic [CNT_W-1:0] w_ftmr_inc;
  assign w_ftmr_inc = r_ftmr + 1'b1;

  // Blink starts lit on the tick that enters the ending window, then toggles
  // every 12th counting tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fcnt  <= '0;
      r_flash <= 1'b0;
    end else if (bus.game_start || w_pellet) begin
      r_fcnt  <= '0;
      r_flash <= (FR_END == '0);
    end else if (w_ftick) begin
      if (w_fexit) begin
        r_fcnt  <= '0;
        r_flash <= 1'b0;
      end else if (w_ftmr_inc == FR_END) begin
        r_fcnt  <= '0;
        r_flash <= 1'b1;
      end else if (w_ending) begin
        if (r_fcnt == 4'd11) begin
          r_fcnt  <= '0;
          r_flash <= !r_flash;
        end else begin
          r_fcnt  <= r_fcnt + 4'd1;
        end
      end
    end
  end
  assign bus.fright_flash = r_flash && w_ending;
`else
  assign bus.fright_flash = 1'b0;
`endif

  assign bus.base_mode     = w_base;
  assign bus.phase         = r_phase;
  assign bus.fright_active = r_fright;
  assign bus.fright_ending = w_ending;
  assign bus.reverse_req   = r_rev;
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
module tb_ghost_mode_scheduler;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler #(
    .SCATTER_FRAMES(4), .CHASE_FRAMES(6), .NUM_PHASES(3),
    .FRIGHT_FRAMES(5), .FLASH_FRAMES(2), .CNT_W(12)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  // Inputs change 1 time unit after a rising edge and are sampled on the next;
  // outputs are read at the same point, after the edge has updated them.
  task automatic tick(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic start();
    bus.game_start = 1'b1;
    @(posedge clk); #1;
    bus.game_start = 1'b0;
  endtask

  task automatic pellet();
    bus.power_pellet = 1'b1;
    @(posedge clk); #1;
    bus.power_pellet = 1'b0;
  endtask

  task automatic eat_home(input logic [3:0] eat, input logic [3:0] home);
    bus.ghost_eaten = eat;
    bus.ghost_home  = home;
    @(posedge clk); #1;
    bus.ghost_eaten = 4'b0;
    bus.ghost_home  = 4'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.game_mode !== 8'h00) begin errors++; $display("FAIL rst_async_mode got %h exp 00", bus.game_mode); end
    @(posedge clk); #1;
    resetN = 1'b1;
    idle_cycle();
    checks++; if (bus.game_mode !== 8'h00) begin errors++; $display("FAIL rst_mode got %h exp 00", bus.game_mode); end
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL rst_phase got %0d exp 0", bus.phase); end
    checks++; if ({bus.base_mode, bus.fright_active, bus.fright_ending, bus.fright_flash, bus.reverse_req} !== 6'b0)
      begin errors++; $display("FAIL rst_flags got %b exp 000000", {bus.base_mode, bus.fright_active, bus.fright_ending, bus.fright_flash, bus.reverse_req}); end
    // IDLE ignores pellets and ticks
    pellet();
    checks++; if ({bus.fright_active, bus.reverse_req} !== 2'b00) begin errors++; $display("FAIL idle_pellet got %b exp 00", {bus.fright_active, bus.reverse_req}); end
    tick(8);
    checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL idle_phase got %0d exp 0", bus.phase); end
  endtask

  task automatic test_schedule();
    int nrev;
    start();
    checks++; if ({bus.phase, bus.base_mode, bus.reverse_req} !== 6'b000_00_0) begin errors++; $display("FAIL sch_start got %b exp 000000", {bus.phase, bus.base_mode, bus.reverse_req}); end
    tick(3);
    checks++; if ({bus.base_mode, bus.reverse_req} !== 3'b00_0) begin errors++; $display("FAIL sch_tick3 got %b exp 000", {bus.base_mode, bus.reverse_req}); end
    tick(1);
    checks++; if ({bus.phase, bus.base_mode, bus.reverse_req} !== 6'b001_01_1) begin errors++; $display("FAIL sch_tick4 got %b exp 001011", {bus.phase, bus.base_mode, bus.reverse_req}); end
    checks++; if (bus.game_mode !== 8'h55) begin errors++; $display("FAIL sch_mode_chase got %h exp 55", bus.game_mode); end
    idle_cycle();
    checks++; if (bus.reverse_req !== 1'b0) begin errors++; $display("FAIL sch_rev_pulse got %b exp 0", bus.reverse_req); end
    tick(5);
    checks++; if ({bus.phase, bus.reverse_req} !== 4'b001_0) begin errors++; $display("FAIL sch_chase5 got %b exp 0010", {bus.phase, bus.reverse_req}); end
    tick(1);
    checks++; if ({bus.phase, bus.base_mode, bus.reverse_req} !== 6'b010_00_1) begin errors++; $display("FAIL sch_phase2 got %b exp 010001", {bus.phase, bus.base_mode, bus.reverse_req}); end
    tick(4);
    checks++; if ({bus.phase, bus.base_mode, bus.reverse_req} !== 6'b011_01_1) begin errors++; $display("FAIL sch_phase3 got %b exp 011011", {bus.phase, bus.base_mode, bus.reverse_req}); end
    nrev = 0;
    repeat (20) begin tick(1); if (bus.reverse_req) nrev++; end
    checks++; if (nrev !== 0) begin errors++; $display("FAIL sch_forever_rev got %0d exp 0", nrev); end
    checks++; if ({bus.phase, bus.base_mode} !== 5'b011_01) begin errors++; $display("FAIL sch_forever got %b exp 01101", {bus.phase, bus.base_mode}); end
  endtask

  task automatic test_fright();
    start();
    tick(4);
    tick(2);
    pellet();
    checks++; if ({bus.fright_active, bus.reverse_req} !== 2'b11) begin errors++; $display("FAIL fr_enter got %b exp 11", {bus.fright_active, bus.reverse_req}); end
    checks++; if (bus.game_mode !== 8'hAA) begin errors++; $display("FAIL fr_mode got %h exp aa", bus.game_mode); end
    tick(2);
    checks++; if ({bus.fright_ending, bus.reverse_req} !== 2'b00) begin errors++; $display("FAIL fr_tick2 got %b exp 00", {bus.fright_ending, bus.reverse_req}); end
    tick(1);
    checks++; if (bus.fright_ending !== 1'b1) begin errors++; $display("FAIL fr_ending got %b exp 1", bus.fright_ending); end
    tick(1);
    checks++; if ({bus.fright_active, bus.fright_ending, bus.phase} !== 5'b11_001) begin errors++; $display("FAIL fr_tick4 got %b exp 11001", {bus.fright_active, bus.fright_ending, bus.phase}); end
    tick(1);
    checks++; if ({bus.fright_active, bus.fright_ending, bus.reverse_req} !== 3'b000) begin errors++; $display("FAIL fr_exit got %b exp 000", {bus.fright_active, bus.fright_ending, bus.reverse_req}); end
    checks++; if (bus.game_mode !== 8'h55) begin errors++; $display("FAIL fr_exit_mode got %h exp 55", bus.game_mode); end
    tick(3);
    checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL fr_resume3 got %0d exp 1", bus.phase); end
    tick(1);
    checks++; if ({bus.phase, bus.reverse_req} !== 4'b010_1) begin errors++; $display("FAIL fr_resume4 got %b exp 0101", {bus.phase, bus.reverse_req}); end
  endtask

  task automatic test_eaten();
    start();
    pellet();
    eat_home(4'b0010, 4'b0000);
    checks++; if (bus.game_mode !== 8'hAE) begin errors++; $display("FAIL eat_g1 got %h exp ae", bus.game_mode); end
    tick(3);
    pellet();
    checks++; if ({bus.game_mode, bus.reverse_req, bus.fright_ending} !== {8'hAE, 2'b10}) begin errors++; $display("FAIL eat_repellet got %h/%b exp ae/10", bus.game_mode, {bus.reverse_req, bus.fright_ending}); end
    eat_home(4'b0000, 4'b0010);
    checks++; if (bus.game_mode !== 8'hA2) begin errors++; $display("FAIL eat_home got %h exp a2", bus.game_mode); end
    eat_home(4'b0000, 4'b0001);
    checks++; if (bus.game_mode !== 8'hA2) begin errors++; $display("FAIL eat_home_ign got %h exp a2", bus.game_mode); end
    eat_home(4'b0100, 4'b0100);
    checks++; if (bus.game_mode !== 8'hB2) begin errors++; $display("FAIL eat_wins got %h exp b2", bus.game_mode); end
    tick(4);
    checks++; if (bus.fright_active !== 1'b1) begin errors++; $display("FAIL eat_fr_hold got %b exp 1", bus.fright_active); end
    tick(1);
    checks++; if ({bus.game_mode, bus.fright_active, bus.phase} !== {8'h30, 1'b0, 3'd0}) begin errors++; $display("FAIL eat_exit got %h/%b/%0d exp 30/0/0", bus.game_mode, bus.fright_active, bus.phase); end
  endtask

  task automatic test_freeze();
    start();
    tick(2);
    bus.freeze = 1'b1;
    tick(10);
    bus.freeze = 1'b0;
    checks++; if ({bus.phase, bus.base_mode, bus.game_mode} !== {3'd0, 2'b00, 8'h00}) begin errors++; $display("FAIL frz_hold got %0d/%b/%h exp 0/00/00", bus.phase, bus.base_mode, bus.game_mode); end
    eat_home(4'b1111, 4'b0000);
    checks++; if (bus.game_mode !== 8'h00) begin errors++; $display("FAIL frz_eat_ign got %h exp 00", bus.game_mode); end
    tick(2);
    checks++; if ({bus.phase, bus.base_mode, bus.reverse_req} !== 6'b001_01_1) begin errors++; $display("FAIL frz_resume got %b exp 001011", {bus.phase, bus.base_mode, bus.reverse_req}); end
    pellet();
    bus.freeze = 1'b1;
    tick(10);
    bus.freeze = 1'b0;
    checks++; if ({bus.fright_active, bus.fright_ending} !== 2'b10) begin errors++; $display("FAIL frz_fright got %b exp 10", {bus.fright_active, bus.fright_ending}); end
  endtask

  task automatic test_async_reset();
    start();
    pellet();
    #2 resetN = 1'b0;
    #1;
    checks++; if ({bus.game_mode, bus.fright_active, bus.reverse_req, bus.phase} !== {8'h00, 2'b00, 3'd0}) begin errors++; $display("FAIL arst got %h/%b/%0d exp 00/00/0", bus.game_mode, {bus.fright_active, bus.reverse_req}, bus.phase); end
    @(posedge clk); #1;
    resetN = 1'b1;
    idle_cycle();
  endtask

  task automatic test_start_mid_fright();
    start();
    tick(4);
    pellet();
    eat_home(4'b0001, 4'b0000);
    checks++; if (bus.game_mode !== 8'hAB) begin errors++; $display("FAIL smf_pre got %h exp ab", bus.game_mode); end
    bus.game_start   = 1'b1;
    bus.power_pellet = 1'b1;
    @(posedge clk); #1;
    bus.game_start   = 1'b0;
    bus.power_pellet = 1'b0;
    checks++; if ({bus.phase, bus.base_mode, bus.fright_active, bus.reverse_req} !== 7'b000_00_0_0) begin errors++; $display("FAIL smf_start got %b exp 0000000", {bus.phase, bus.base_mode, bus.fright_active, bus.reverse_req}); end
    checks++; if (bus.game_mode !== 8'h00) begin errors++; $display("FAIL smf_mode got %h exp 00", bus.game_mode); end
  endtask

  initial begin
    bus.frame_tick   = 1'b0;
    bus.game_start   = 1'b0;
    bus.freeze       = 1'b0;
    bus.power_pellet = 1'b0;
    bus.ghost_eaten  = 4'b0;
    bus.ghost_home   = 4'b0;
    test_reset();
    test_schedule();
    test_fright();
    test_eaten();
    test_freeze();
    test_async_reset();
    test_start_mid_fright();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
